// File: rtl/rot_cmd_ctrl.sv
// rot_cmd_ctrl
// Queues rotate commands and sequences an external combinational 8-bit
// rotator. Each command makes 1 to 4 passes, with the rotator result fed
// back each pass. The final byte is presented on a valid/ready result port.
//
// Ports
//   clk, rst              : single clock; synchronous active-high reset
//   cmd_valid/cmd_ready   : command handshake
//   cmd_data/amt/left/rep : byte, per-pass amount, direction (1 = left),
//                           extra passes (total passes = rep + 1)
//   rot_in/rot_sel/rot_left : drive the external rotator
//   rot_out               : rotator result (combinational from rot_*)
//   res_valid/res_ready   : result handshake
//   res_data              : final rotated byte
//   busy                  : a command is active or queued
module rot_cmd_ctrl #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [7:0] cmd_data,
    input  logic [2:0] cmd_amt,
    input  logic       cmd_left,
    input  logic [1:0] cmd_rep,
    output logic [7:0] rot_in,
    output logic [2:0] rot_sel,
    output logic       rot_left,
    input  logic [7:0] rot_out,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       busy
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROT  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic [2:0] amt;
        logic       left;
        logic [1:0] rep;
    } cmd_t;

    state_t           state_q, state_d;
    logic [7:0]       work_q, work_d;
    logic [2:0]       amt_q, amt_d;
    logic             left_q, left_d;
    logic [1:0]       passes_q, passes_d;

    cmd_t             mem_q [FIFO_DEPTH];
    cmd_t             mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic             full_s;
    logic             empty_s;
    logic             cmd_ready_s;
    logic             push_s;
    logic             pop_s;
    cmd_t             cmd_in_s;
    cmd_t             head_s;

    // FIFO status and handshake qualifiers. A full FIFO refuses a push even
    // when the FSM pops in the same cycle, so the push never depends on the pop.
    always_comb begin
        full_s      = (count_q == CNT_W'(FIFO_DEPTH));
        empty_s     = (count_q == {CNT_W{1'b0}});
        cmd_ready_s = !full_s && !rst;
        push_s      = cmd_valid && cmd_ready_s;
        pop_s       = (state_q == ST_IDLE) && !empty_s;
        cmd_in_s    = '{data: cmd_data, amt: cmd_amt, left: cmd_left, rep: cmd_rep};
        head_s      = mem_q[rd_ptr_q];
    end

    // FIFO next state: storage write, pointer advance, occupancy count.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_s) begin
            mem_d[wr_ptr_q] = cmd_in_s;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Controller next state: load from FIFO head, iterate passes, hold result.
    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        amt_d    = amt_q;
        left_d   = left_q;
        passes_d = passes_q;
        case (state_q)
            ST_IDLE: begin
                if (pop_s) begin
                    work_d   = head_s.data;
                    amt_d    = head_s.amt;
                    left_d   = head_s.left;
                    passes_d = head_s.rep;
                    state_d  = ST_ROT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ROT: begin
                // Every pass captures the rotator result, including the last.
                work_d = rot_out;
                if (passes_q == 2'd0) begin
                    state_d = ST_DONE;
                end else begin
                    passes_d = passes_q - 2'd1;
                    state_d  = ST_ROT;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset; reset discards queued and active work.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            work_q   <= 8'h00;
            amt_q    <= 3'd0;
            left_q   <= 1'b0;
            passes_q <= 2'd0;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            amt_q    <= amt_d;
            left_q   <= left_d;
            passes_q <= passes_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Outputs decode registered state only; res_valid never depends on res_ready.
    assign cmd_ready = cmd_ready_s;
    assign rot_in    = work_q;
    assign rot_sel   = amt_q;
    assign rot_left  = left_q;
    assign res_valid = (state_q == ST_DONE);
    assign res_data  = work_q;
    assign busy      = (state_q != ST_IDLE) || !empty_s;

endmodule

// File: tb/tb_rot_cmd_ctrl.sv
// Directed bench for rot_cmd_ctrl with a behavioural rotator on rot_*.
module tb_rot_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_data;
    logic [2:0] cmd_amt;
    logic       cmd_left;
    logic [1:0] cmd_rep;
    logic [7:0] rot_in;
    logic [2:0] rot_sel;
    logic       rot_left;
    logic [7:0] rot_out;
    logic       res_valid;
    logic       res_ready;
    logic [7:0] res_data;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    rot_cmd_ctrl #(.FIFO_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_data  (cmd_data),
        .cmd_amt   (cmd_amt),
        .cmd_left  (cmd_left),
        .cmd_rep   (cmd_rep),
        .rot_in    (rot_in),
        .rot_sel   (rot_sel),
        .rot_left  (rot_left),
        .rot_out   (rot_out),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Behavioural rotator: left out[i] = in[i-k], right out[i] = in[i+k] (mod 8).
    always_comb begin
        logic [2:0] idx;
        rot_out = 8'h00;
        idx     = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (rot_left) idx = 3'(i) - rot_sel;
            else          idx = 3'(i) + rot_sel;
            rot_out[i] = rot_in[idx];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; the command must be accepted at the next rising edge.
    task automatic push_now(input string tag, input logic [7:0] d, input logic [2:0] a,
                            input logic l, input logic [1:0] r);
        cmd_valid = 1'b1;
        cmd_data  = d;
        cmd_amt   = a;
        cmd_left  = l;
        cmd_rep   = r;
        #1;
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Waits (bounded) for res_valid, checks latency in falling edges and data, then consumes it.
    task automatic get_result(input string tag, input logic [7:0] exp, input int lat);
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(res_valid), 32'd1);
        if (lat >= 0) check({tag, "_lat"}, 32'(n), 32'(lat));
        check({tag, "_data"}, 32'(res_data), 32'(exp));
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int seen;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_data  = 8'h00;
        cmd_amt   = 3'd0;
        cmd_left  = 1'b0;
        cmd_rep   = 2'd0;
        res_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'h00);
        check("rst_rot_in", 32'(rot_in), 32'h00);
        check("rst_rot_sel", 32'(rot_sel), 32'd0);
        check("rst_rot_left", 32'(rot_left), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);

        // Basic commands
        push_now("t1", 8'h81, 3'd1, 1'b1, 2'd0);
        get_result("t1", 8'h03, 2);
        check("t1_busy_after", 32'(busy), 32'd0);
        push_now("t2", 8'h01, 3'd1, 1'b0, 2'd0);
        get_result("t2", 8'h80, 2);
        push_now("t3", 8'h01, 3'd3, 1'b1, 2'd2);
        get_result("t3", 8'h02, 4);
        push_now("t4", 8'hA5, 3'd0, 1'b1, 2'd3);
        get_result("t4", 8'hA5, 5);

        // Backpressure: result held 10 cycles, next queued result follows
        push_now("bp1", 8'h0F, 3'd4, 1'b1, 2'd0);
        push_now("bp2", 8'h12, 3'd1, 1'b0, 2'd1);
        n = 0;
        while (res_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            check("bp_hold_valid", 32'(res_valid), 32'd1);
            check("bp_hold_data", 32'(res_data), 32'hF0);
            @(negedge clk);
        end
        get_result("bp1", 8'hF0, 0);
        get_result("bp2", 8'h84, 3);

        // Full FIFO: one active plus four queued, sixth command blocked
        push_now("f1", 8'h81, 3'd1, 1'b1, 2'd0);
        push_now("f2", 8'h81, 3'd1, 1'b0, 2'd0);
        push_now("f3", 8'h3C, 3'd2, 1'b1, 2'd0);
        push_now("f4", 8'h96, 3'd4, 1'b0, 2'd0);
        push_now("f5", 8'h01, 3'd7, 1'b1, 2'd0);
        cmd_valid = 1'b1;
        cmd_data  = 8'h80;
        cmd_amt   = 3'd1;
        cmd_left  = 1'b1;
        cmd_rep   = 2'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("full_cmd_ready", 32'(cmd_ready), 32'd0);
            @(negedge clk);
        end
        get_result("f1", 8'h03, -1);
        n = 0;
        while (cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("f6_accept", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        get_result("f2", 8'hC0, -1);
        get_result("f3", 8'hF0, -1);
        get_result("f4", 8'h69, -1);
        get_result("f5", 8'h80, -1);
        get_result("f6", 8'h02, -1);
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        check("full_no_dup", 32'(seen), 32'd0);
        check("full_busy_idle", 32'(busy), 32'd0);

        // Simultaneous push/pop with two entries queued
        push_now("s_p", 8'hF0, 3'd4, 1'b0, 2'd0);
        push_now("s_x", 8'h02, 3'd1, 1'b1, 2'd0);
        push_now("s_y", 8'h40, 3'd6, 1'b0, 2'd0);
        get_result("s_p", 8'h0F, -1);
        push_now("s_z", 8'h55, 3'd1, 1'b1, 2'd0);
        push_now("s_w1", 8'hC3, 3'd4, 1'b1, 2'd0);
        push_now("s_w2", 8'h7F, 3'd1, 1'b0, 2'd0);
        check("s_full_after", 32'(cmd_ready), 32'd0);
        get_result("s_x", 8'h04, -1);
        get_result("s_y", 8'h01, -1);
        get_result("s_z", 8'hAA, -1);
        get_result("s_w1", 8'h3C, -1);
        get_result("s_w2", 8'hBF, -1);

        // Reset during ROT with two entries queued
        push_now("r_a", 8'h11, 3'd1, 1'b1, 2'd3);
        push_now("r_b", 8'h22, 3'd1, 1'b1, 2'd0);
        push_now("r_c", 8'h33, 3'd1, 1'b1, 2'd0);
        rst = 1'b1;
        #1;
        check("mid_rst_cmd_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_rot_in", 32'(rot_in), 32'h00);
        rst = 1'b0;
        #1;
        check("mid_rst_cmd_ready_after", 32'(cmd_ready), 32'd1);
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (res_valid || busy) seen++;
        end
        check("mid_rst_no_stale", 32'(seen), 32'd0);
        push_now("r_new", 8'h81, 3'd1, 1'b1, 2'd0);
        get_result("r_new", 8'h03, 2);
        check("r_new_busy_after", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
